// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request/response signals and the memory-macro
// side request signals handled by mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int WORD_LEN = 32
);
    logic                if_req;
    logic [WORD_LEN-1:0] if_addr;
    logic [WORD_LEN-1:0] if_rdata;
    logic                if_valid;
    logic                if_stall;
    logic                mem_rd;
    logic                mem_wr;
    logic [WORD_LEN-1:0] mem_addr;
    logic [WORD_LEN-1:0] mem_wdata;
    logic [WORD_LEN-1:0] mem_rdata;
    logic                mem_valid;
    logic                mem_stall;
    logic                ram_req;
    logic                ram_we;
    logic [WORD_LEN-1:0] ram_addr;
    logic [WORD_LEN-1:0] ram_wdata;
    logic [WORD_LEN-1:0] ram_rdata;
    logic                ram_ready;
    logic                bus_err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  ram_rdata, ram_ready,
        output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
        output ram_req, ram_we, ram_addr, ram_wdata, bus_err
    );

    // Pipeline stages plus memory macro side
    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        output ram_rdata, ram_ready,
        input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
        input  ram_req, ram_we, ram_addr, ram_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (MEM). MEM is preferred because it holds the older instruction;
// a run counter forces an IF grant after MAX_MEM_RUN back-to-back MEM grants.
// Accesses that never see ram_ready are aborted after TIMEOUT_CYC cycles.
module mem_port_arbiter #(
    parameter int WORD_LEN    = 32,
    parameter int MAX_MEM_RUN = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] RUN_LIMIT = 4'(MAX_MEM_RUN);
    // Abort happens in the TIMEOUT_CYC-th BUSY cycle, where the count still reads one less
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYC - 1);

    state_t              state_q;
    state_t              state_d;
    logic                grant_mem_q;
    logic                we_q;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic [WORD_LEN-1:0] if_rdata_q;
    logic [WORD_LEN-1:0] mem_rdata_q;
    logic [3:0]          mem_run_q;
    logic [7:0]          tmo_cnt_q;
    logic                bus_err_q;

    logic any_mem;
    logic any_req;
    logic pick_mem;
    logic ram_done;
    logic ram_abort;

    assign any_mem   = bus.mem_rd | bus.mem_wr;
    assign any_req   = any_mem | bus.if_req;
    // MEM wins unless IF is waiting and MEM has used up its run allowance
    assign pick_mem  = any_mem & ~(bus.if_req & (mem_run_q == RUN_LIMIT));
    // ram_ready beats a simultaneous timeout
    assign ram_done  = (state_q == BUSY) & bus.ram_ready;
    assign ram_abort = (state_q == BUSY) & ~bus.ram_ready & (tmo_cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (ram_done || ram_abort) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's access at grant time; held stable for the whole BUSY phase
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_mem_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else if (state_q == IDLE && any_req) begin
            grant_mem_q <= pick_mem;
            we_q        <= pick_mem & bus.mem_wr;
            addr_q      <= pick_mem ? bus.mem_addr : bus.if_addr;
            wdata_q     <= pick_mem ? bus.mem_wdata : '0;
        end
    end

    // Anti-starvation run counter and access timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_run_q <= '0;
            tmo_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            tmo_cnt_q <= '0;
            if (!bus.if_req || !pick_mem) begin
                mem_run_q <= '0;
            end else if (mem_run_q != 4'd15) begin
                mem_run_q <= mem_run_q + 4'd1;
            end
        end else if (state_q == BUSY && !bus.ram_ready) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    // Capture read data (zero on abort) and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else if (ram_done || ram_abort) begin
            if (ram_abort) begin
                bus_err_q <= 1'b1;
            end
            if (!we_q) begin
                if (grant_mem_q) begin
                    mem_rdata_q <= ram_done ? bus.ram_rdata : '0;
                end else begin
                    if_rdata_q <= ram_done ? bus.ram_rdata : '0;
                end
            end
        end
    end

    assign bus.ram_req   = (state_q == BUSY);
    assign bus.ram_we    = (state_q == BUSY) & we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.if_valid  = (state_q == RESP) & ~grant_mem_q;
    assign bus.mem_valid = (state_q == RESP) & grant_mem_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_valid;
    assign bus.mem_stall = any_mem & ~bus.mem_valid;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written
// contention/reset sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int W      = 32;
    localparam int MAXRUN = 4;
    localparam int TMO    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORD_LEN(W)) bus ();

    mem_port_arbiter #(
        .WORD_LEN   (W),
        .MAX_MEM_RUN(MAXRUN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        use_if;
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // BUSY cycle carrying ram_ready; 0 = never
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    // reference-model state
    logic        if_pend, m_pend, m_wr, win_mem, timed_out, busy_ok, exp_err;
    logic [31:0] if_a, m_a, m_d, rd_val, exp_addr, exp_if_rdata, exp_mem_rdata, v;
    int          run, d, resp, r;

    initial begin
        vecs[0] = '{"if_fetch",       1'b1, 1'b0, 32'h40,  32'h0,        32'h1234,     1, 32'h1234,     1'b0};
        vecs[1] = '{"load",           1'b0, 1'b0, 32'h80,  32'h0,        32'h55AA1234, 2, 32'h55AA1234, 1'b0};
        vecs[2] = '{"store",          1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'hBAD0BAD0, 3, 32'h55AA1234, 1'b0};
        vecs[3] = '{"ready_at_limit", 1'b0, 1'b0, 32'h84,  32'h0,        32'hCAFEF00D, 8, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{"timeout",        1'b0, 1'b0, 32'h88,  32'h0,        32'h77777777, 0, 32'h0,        1'b1};

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.ram_rdata = '0; bus.ram_ready = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_ram_req",   32'(bus.ram_req),   32'd0);
        chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
        chk("rst_ram_addr",  bus.ram_addr,       32'd0);
        chk("rst_ram_wdata", bus.ram_wdata,      32'd0);
        chk("rst_valids",    32'({bus.if_valid, bus.mem_valid}), 32'd0);
        chk("rst_stalls",    32'({bus.if_stall, bus.mem_stall}), 32'd0);
        chk("rst_rdata",     bus.if_rdata | bus.mem_rdata, 32'd0);
        chk("rst_bus_err",   32'(bus.bus_err),   32'd0);
        rst = 1'b0;
        tick();
        chk("idle_no_req",   32'(bus.ram_req),   32'd0);

        // directed vector table
        for (int i = 0; i < 5; i++) begin
            resp = (vecs[i].delay == 0) ? TMO + 1 : vecs[i].delay + 1;
            bus.if_req    = vecs[i].use_if;
            bus.if_addr   = vecs[i].use_if ? vecs[i].addr : 32'h0;
            bus.mem_rd    = !vecs[i].use_if && !vecs[i].is_wr;
            bus.mem_wr    = !vecs[i].use_if && vecs[i].is_wr;
            bus.mem_addr  = vecs[i].use_if ? 32'h0 : vecs[i].addr;
            bus.mem_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("%s_stall_c0", vecs[i].name),
                32'(vecs[i].use_if ? bus.if_stall : bus.mem_stall), 32'd1);
            busy_ok = 1'b1;
            for (int c = 1; c < resp; c++) begin
                tick();
                if (!(bus.ram_req === 1'b1 && bus.ram_addr === vecs[i].addr &&
                      bus.ram_we === vecs[i].is_wr &&
                      (!vecs[i].is_wr || bus.ram_wdata === vecs[i].wdata) &&
                      (vecs[i].use_if ? bus.if_stall : bus.mem_stall) === 1'b1 &&
                      bus.if_valid === 1'b0 && bus.mem_valid === 1'b0))
                    busy_ok = 1'b0;
                bus.ram_ready = (c == vecs[i].delay);
                bus.ram_rdata = (c == vecs[i].delay) ? vecs[i].rdata : $urandom();
            end
            chk($sformatf("%s_busy_phase", vecs[i].name), 32'(busy_ok), 32'd1);
            tick();
            bus.ram_ready = 1'b0;
            chk($sformatf("%s_valid", vecs[i].name), 32'({bus.if_valid, bus.mem_valid}),
                vecs[i].use_if ? 32'd2 : 32'd1);
            chk($sformatf("%s_rdata", vecs[i].name),
                vecs[i].use_if ? bus.if_rdata : bus.mem_rdata, vecs[i].exp_rdata);
            chk($sformatf("%s_stall_resp", vecs[i].name),
                32'(vecs[i].use_if ? bus.if_stall : bus.mem_stall), 32'd0);
            chk($sformatf("%s_bus_err", vecs[i].name), 32'(bus.bus_err), 32'(vecs[i].exp_err));
            chk($sformatf("%s_req_drop", vecs[i].name), 32'(bus.ram_req), 32'd0);
            bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
            tick();
            chk($sformatf("%s_pulse_end", vecs[i].name),
                32'({bus.if_valid, bus.mem_valid, bus.ram_req}), 32'd0);
        end

        // reset during the second BUSY cycle
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h200;
        tick();
        chk("rstbusy_req_c1", 32'(bus.ram_req), 32'd1);
        tick();
        chk("rstbusy_err_sticky", 32'(bus.bus_err), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstbusy_req_drop", 32'(bus.ram_req), 32'd0);
        chk("rstbusy_no_valid", 32'({bus.if_valid, bus.mem_valid}), 32'd0);
        chk("rstbusy_err_clr",  32'(bus.bus_err), 32'd0);
        rst = 1'b0; bus.mem_rd = 1'b0;
        busy_ok = 1'b1;
        repeat (3) begin
            tick();
            if (bus.ram_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.mem_valid !== 1'b0) busy_ok = 1'b0;
        end
        chk("rstbusy_quiet_after", 32'(busy_ok), 32'd1);

        // contention: both held, ready every access
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.mem_rd = 1'b1; bus.mem_addr = 32'h300;
        bus.ram_ready = 1'b1; bus.ram_rdata = 32'h0C0C0C0C;
        busy_ok = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (bus.if_stall !== 1'b1) busy_ok = 1'b0;
            chk($sformatf("contend_addr%0d", t), bus.ram_addr, (t < 4) ? 32'h300 : 32'h400);
            tick();
            chk($sformatf("contend_grant%0d", t), 32'({bus.if_valid, bus.mem_valid}),
                (t < 4) ? 32'd1 : 32'd2);
            if (t < 4 && bus.if_stall !== 1'b1) busy_ok = 1'b0;
            if (t == 4) begin
                bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.ram_ready = 1'b0;
            end
            tick();
            if (t < 4 && bus.if_stall !== 1'b1) busy_ok = 1'b0;
        end
        chk("contend_if_stall_held", 32'(busy_ok), 32'd1);

        // randomized traffic against a transaction-level model
        if_pend = 1'b0; m_pend = 1'b0; m_wr = 1'b0; if_a = '0; m_a = '0; m_d = '0;
        run = 0; exp_err = 1'b0;
        exp_if_rdata = 32'h0C0C0C0C; exp_mem_rdata = 32'h0C0C0C0C;
        for (int n = 0; n < 300; n++) begin
            if (!if_pend && $urandom_range(0, 2) != 0) begin if_pend = 1'b1; if_a = $urandom(); end
            if (!m_pend && $urandom_range(0, 2) != 0) begin
                m_pend = 1'b1; m_wr = 1'($urandom_range(0, 1)); m_a = $urandom(); m_d = $urandom();
            end
            if (!if_pend && !m_pend) begin if_pend = 1'b1; if_a = $urandom(); end
            bus.if_req = if_pend; bus.if_addr = if_a;
            bus.mem_rd = m_pend && !m_wr; bus.mem_wr = m_pend && m_wr;
            bus.mem_addr = m_a; bus.mem_wdata = m_d;

            // MEM preferred unless IF has waited through MAXRUN MEM grants
            win_mem = m_pend && !(if_pend && run == MAXRUN);
            if (!if_pend || !win_mem) run = 0;
            else if (run < 15) run = run + 1;
            r = int'($urandom_range(0, 19));
            d = (r == 0) ? TMO + 1 : (r == 1) ? TMO : int'($urandom_range(1, 4));
            timed_out = (d > TMO);
            resp = timed_out ? TMO + 1 : d + 1;
            rd_val = $urandom();
            exp_addr = win_mem ? m_a : if_a;

            busy_ok = 1'b1;
            for (int c = 1; c < resp; c++) begin
                tick();
                if (!(bus.ram_req === 1'b1 && bus.ram_addr === exp_addr &&
                      bus.ram_we === (win_mem && m_wr) &&
                      (!(win_mem && m_wr) || bus.ram_wdata === m_d) &&
                      bus.if_stall === if_pend && bus.mem_stall === m_pend &&
                      bus.if_valid === 1'b0 && bus.mem_valid === 1'b0))
                    busy_ok = 1'b0;
                bus.ram_ready = (c == d);
                bus.ram_rdata = (c == d) ? rd_val : $urandom();
            end
            chk($sformatf("rand%0d_busy", n), 32'(busy_ok), 32'd1);
            tick();
            bus.ram_ready = 1'b0;
            if (!(win_mem && m_wr)) begin
                v = timed_out ? 32'h0 : rd_val;
                if (win_mem) exp_mem_rdata = v;
                else exp_if_rdata = v;
            end
            if (timed_out) exp_err = 1'b1;
            chk($sformatf("rand%0d_valid", n), 32'({bus.if_valid, bus.mem_valid}),
                win_mem ? 32'd1 : 32'd2);
            chk($sformatf("rand%0d_rdata", n), win_mem ? bus.mem_rdata : bus.if_rdata,
                win_mem ? exp_mem_rdata : exp_if_rdata);
            chk($sformatf("rand%0d_stalls", n), 32'({bus.if_stall, bus.mem_stall}),
                32'({if_pend && win_mem, m_pend && !win_mem}));
            chk($sformatf("rand%0d_bus_err", n), 32'(bus.bus_err), 32'(exp_err));
            if (win_mem) m_pend = 1'b0;
            else if_pend = 1'b0;
            bus.if_req = if_pend; bus.mem_rd = m_pend && !m_wr; bus.mem_wr = m_pend && m_wr;
            tick();
            chk($sformatf("rand%0d_idle", n), 32'({bus.ram_req, bus.if_valid, bus.mem_valid}), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
